store_buffer: RTL

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/store_buffer.sv
// Store buffer: a small FIFO of committed stores waiting to drain into the
// d-cache, with combinational store-to-load forwarding for aligned word loads.
// The youngest store covering the load's word decides the outcome: an aligned
// word store forwards its data, while a byte store or a misaligned word store
// forces the load to stall or retry.
module store_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     store_en,
  input  logic                     store_isbyte,
  input  logic [19:0]              store_addr,
  input  logic [31:0]              store_data,
  output logic                     drain_valid,
  input  logic                     drain_ready,
  output logic [19:0]              drain_addr,
  output logic                     drain_isbyte,
  output logic [31:0]              drain_data,
  input  logic [19:0]              lookup_addr,
  output logic                     lookup_hit,
  output logic [31:0]              lookup_data,
  output logic                     lookup_conflict,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [19:0]   r_addr   [DEPTH];
  logic          r_isbyte [DEPTH];
  logic [31:0]   r_data   [DEPTH];
  logic [AW-1:0] r_wrPtr;
  logic [AW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic          w_push;
  logic          w_pop;
  logic          w_found;
  logic          w_foundIsByte;
  logic [1:0]    w_foundLsb;
  logic [31:0]   w_foundData;
  logic          w_unusedLookupLsb;

  // The low address bits of a load never take part in the word match.
  assign w_unusedLookupLsb = ^lookup_addr[1:0];

  assign full        = (r_count == CW'(DEPTH));
  assign empty       = (r_count == '0);
  assign count       = r_count;
  assign overflow    = r_overflow;
  assign drain_valid = ~empty;

  // A full buffer still accepts a store when the head leaves in the same cycle.
  assign w_pop  = drain_valid & drain_ready;
  assign w_push = store_en & (~full | w_pop);

  // Head fields are gated by empty so stale contents never leak after reset.
  assign drain_addr   = empty ? '0   : r_addr[r_rdPtr];
  assign drain_isbyte = empty ? 1'b0 : r_isbyte[r_rdPtr];
  assign drain_data   = empty ? '0   : r_data[r_rdPtr];

  // Entry storage carries no reset; the pointers and count decide what is live.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wrPtr]   <= store_addr;
      r_isbyte[r_wrPtr] <= store_isbyte;
      r_data[r_wrPtr]   <= store_data;
    end
  end

  // Pointer, occupancy and sticky overflow bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
      if (store_en && full && !w_pop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Walk live entries oldest to youngest so the last match is the youngest.
  always_comb begin
    w_found       = 1'b0;
    w_foundIsByte = 1'b0;
    w_foundLsb    = 2'b00;
    w_foundData   = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if ((CW'(k) < r_count) &&
          (r_addr[r_rdPtr + AW'(k)][19:2] == lookup_addr[19:2])) begin
        w_found       = 1'b1;
        w_foundIsByte = r_isbyte[r_rdPtr + AW'(k)];
        w_foundLsb    = r_addr[r_rdPtr + AW'(k)][1:0];
        w_foundData   = r_data[r_rdPtr + AW'(k)];
      end
    end
  end

  assign lookup_hit      = w_found & ~w_foundIsByte & (w_foundLsb == 2'b00);
  assign lookup_conflict = w_found & ~lookup_hit;
  assign lookup_data     = lookup_hit ? w_foundData : '0;

endmodule
